dflow_qdr_sched: RTL and testbench
==================================

# dflow_qdr_sched

Single-port QDR command scheduler for the dflow generator. It shares the QDR user interface between two requesters: the tuple record path, which writes 144-bit 5-tuple/length records into a circular region, and the replay path, which reads them back for emission. Arbitration is weighted round-robin. Reads are credit-limited by an internal return FIFO, because QDR read data cannot be back-pressured. The block sits between the tuple ingress/egress logic and the QDR controller, in the QDR clock domain.

## Interface
- ADDR_W, 19, QDR word address width
- DATA_W, 144, record width
- RD_FIFO_DEPTH, 16, return FIFO depth; power of 2, ≥4
- WR_WEIGHT, 4, max consecutive write grants while a read is eligible
- RD_WEIGHT, 4, max consecutive read grants while a write is pending

- clk  in  1  QDR-domain clock (driven by qdr_clk)
- aresetn  in  1  async active-low reset
- cfg_enable  in  1  run enable; rising edge loads pointers
- cfg_replay_en  in  1  allow replay reads
- cfg_base / cfg_limit  in  ADDR_W  circular region, limit inclusive, base ≤ limit
- rec_count  out  ADDR_W+1  valid records stored, saturating
- wr_data  in  DATA_W  record to store
- wr_vld / wr_ready  in/out  1  record handshake
- rd_data  out  DATA_W  replayed record
- rd_vld / rd_ready  out/in  1  replay handshake
- init_calib_complete  in  1  QDR ready
- user_app_wr_cmd0, user_app_wr_addr0, user_app_wr_data0  out  1/ADDR_W/DATA_W  write command
- user_app_rd_cmd0, user_app_rd_addr0  out  1/ADDR_W  read command
- user_app_rd_valid0, user_app_rd_data0  in  1/DATA_W  read return
- stat_wr_cnt, stat_rd_cnt, stat_drop_cnt  out  32  statistics

## Operation
- FSM states: OFF, WR_PH, RD_PH. OFF when !init_calib_complete or !cfg_enable. The exit state is WR_PH.
- Rising edge of cfg_enable: rec_ptr = rep_ptr = cfg_base, rec_count = 0. cfg_base/cfg_limit are only sampled here.
- At most one QDR command per cycle.
- Write eligible: wr_vld, state ≠ OFF. Read eligible: cfg_replay_en, rec_count > 0, credit > 0.
- credit = RD_FIFO_DEPTH − fifo_occupancy − outstanding.
- WR_PH grants writes. It moves to RD_PH after WR_WEIGHT consecutive grants with a read eligible, or when no write is pending and a read is eligible.
- RD_PH is symmetric with RD_WEIGHT. The burst counter resets on each phase change.
- Write grant: issue at rec_ptr. rec_ptr wraps from cfg_limit to cfg_base. rec_count increments, saturating at limit−base+1.
- Read grant: issue at rep_ptr. rep_ptr wraps to cfg_base after cfg_limit, or after the last written address if not yet full. outstanding increments.
- Return: user_app_rd_valid0 pushes into the FIFO and decrements outstanding. A return with outstanding = 0 is dropped and increments stat_drop_cnt.
- cfg_enable falling: no new commands are issued. Outstanding returns are still accepted and drained to rd_*.
- No read/write address hazard checking. Replaying an address being overwritten yields either old or new data.

## Timing
- Reset values:
  - all cmd outputs 0; addr and data outputs 0
  - wr_ready 0, rd_vld 0
  - rec_count 0, stats 0
  - state OFF; pointers 0
- wr_ready is combinational from state and eligibility only, never from wr_vld.
- Write: handshake in cycle N → user_app_wr_cmd0, addr and data registered, high in N+1 for one cycle.
- Read: grant in N → user_app_rd_cmd0 high in N+1.
- Return in cycle M → rd_vld no earlier than M+1. rd_data/rd_vld are stable until rd_ready.
- FIFO overflow is impossible by credit; an overflow indicates a design bug (assertion).
- Simultaneous FIFO push and pop in the same cycle: occupancy is unchanged.

## Configuration
- DFLOW_QDR_SCHED_STATS_EN defined: stat_wr_cnt, stat_rd_cnt and stat_drop_cnt count write commands, read commands and dropped returns, wrapping at 2^32.
- Not defined: all three ports are tied to 0 and the counters are not synthesized. Drop detection still discards the data.

## Structure
- Package dflow_pkg holds:
  - DFLOW_ADDR_W, DFLOW_REC_W
  - the FSM state enum (OFF/WR_PH/RD_PH)
- One sub-module, dflow_sync_fifo: single-clock, first-word-fall-through, exposing a count. It is used as the return FIFO.

## Test plan
- Calibration gating: init_calib_complete = 0 with wr_vld = 1 → wr_ready stays 0 and no cmds for 100 cycles. Assert calib → first wr_cmd at cfg_base next cycle.
- Record wrap: base = 10, limit = 13, 6 writes → addrs 10, 11, 12, 13, 10, 11; rec_count = 4.
- Weighted arbitration: both paths saturated, weights 4/4 → command pattern W×4, R×4 repeating.
- Credit limit: RD_FIFO_DEPTH = 16, rd_ready = 0, 40 records stored → exactly 16 read cmds issued, then none until rd_ready pops.
- Replay wrap on partial fill: 3 records at base 0 → read addrs 0, 1, 2, 0, 1… with data matching the written data.
- Reset and drop: aresetn pulse with 5 reads outstanding → all outputs at reset values. 5 late returns → stat_drop_cnt = 5 (STATS_EN), rd_vld stays 0.

Source files
------------

// File: rtl/dflow_pkg.sv
// Shared definitions for the dflow QDR scheduler slice: default widths and
// the scheduler phase encoding.
package dflow_pkg;

    localparam int unsigned DFLOW_ADDR_W = 19;
    localparam int unsigned DFLOW_REC_W  = 144;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        WR_PH = 2'd1,
        RD_PH = 2'd2
    } sched_state_e;

endpackage

// File: rtl/dflow_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with an occupancy count.
// The head entry is visible on pop_data whenever empty is low.
module dflow_sync_fifo #(
    parameter int unsigned WIDTH = 144,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == (PTR_W + 1)'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    // Storage array; no reset needed since contents are qualified by count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy tracking; push+pop together leaves count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + (PTR_W + 1)'(do_push) - (PTR_W + 1)'(do_pop);
        end
    end

    // Upstream credit accounting must never push into a full FIFO without a pop.
    assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop));

endmodule

// File: rtl/dflow_qdr_sched.sv
// QDR command scheduler: weighted round-robin between the record write path
// and the credit-limited replay read path, sharing one QDR user port.
// Optional statistics counters are built when DFLOW_QDR_SCHED_STATS_EN is defined.
module dflow_qdr_sched
    import dflow_pkg::*;
#(
    parameter int unsigned ADDR_W        = DFLOW_ADDR_W,
    parameter int unsigned DATA_W        = DFLOW_REC_W,
    parameter int unsigned RD_FIFO_DEPTH = 16,
    parameter int unsigned WR_WEIGHT     = 4,
    parameter int unsigned RD_WEIGHT     = 4
) (
    input  logic              clk,
    input  logic              aresetn,
    input  logic              cfg_enable,
    input  logic              cfg_replay_en,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [ADDR_W-1:0] cfg_limit,
    output logic [ADDR_W:0]   rec_count,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_vld,
    output logic              wr_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_vld,
    input  logic              rd_ready,
    input  logic              init_calib_complete,
    output logic              user_app_wr_cmd0,
    output logic [ADDR_W-1:0] user_app_wr_addr0,
    output logic [DATA_W-1:0] user_app_wr_data0,
    output logic              user_app_rd_cmd0,
    output logic [ADDR_W-1:0] user_app_rd_addr0,
    input  logic              user_app_rd_valid0,
    input  logic [DATA_W-1:0] user_app_rd_data0,
    output logic [31:0]       stat_wr_cnt,
    output logic [31:0]       stat_rd_cnt,
    output logic [31:0]       stat_drop_cnt
);

    localparam int unsigned CNT_W   = $clog2(RD_FIFO_DEPTH) + 1;
    localparam int unsigned BURST_W = 8;

    sched_state_e       state;
    sched_state_e       state_nxt;
    sched_state_e       ph;
    logic [BURST_W-1:0] burst;
    logic [BURST_W-1:0] burst_nxt;

    logic               cfg_en_q;
    logic               en_rise;
    logic               run;
    logic [ADDR_W-1:0]  base_q;
    logic [ADDR_W-1:0]  limit_q;
    logic [ADDR_W-1:0]  rec_ptr;
    logic [ADDR_W-1:0]  rep_ptr;
    logic [ADDR_W:0]    cap;
    logic               rec_full;
    logic               rep_last;

    logic [CNT_W-1:0]   outstanding;
    logic [CNT_W-1:0]   fifo_count;
    logic [CNT_W-1:0]   credit;
    logic               fifo_empty;
    logic               ret_ok;

    logic               wr_go;
    logic               rd_go;
    logic               rd_elig;

    // Pointers are only trusted one cycle after the enable edge loads them,
    // so the scheduler runs from the cycle after cfg_enable is seen high.
    assign en_rise  = cfg_enable && !cfg_en_q;
    assign run      = init_calib_complete && cfg_enable && cfg_en_q;
    assign cap      = ({1'b0, limit_q} - {1'b0, base_q}) + 1'b1;
    assign rec_full = (rec_count >= cap);
    assign rep_last = (rep_ptr == limit_q) || (!rec_full && ((rep_ptr + 1'b1) == rec_ptr));
    assign credit   = CNT_W'(RD_FIFO_DEPTH) - fifo_count - outstanding;
    assign ret_ok   = user_app_rd_valid0 && (outstanding != '0);
    assign rd_vld   = !fifo_empty;

    // Phase register and burst counter.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state <= OFF;
            burst <= '0;
        end else begin
            state <= state_nxt;
            burst <= burst_nxt;
        end
    end

    // Arbitration: effective phase, grants, and next phase/burst.
    // OFF is treated as WR_PH as soon as the run conditions hold, so the
    // first write can be accepted in the cycle calibration completes.
    always_comb begin
        ph        = state;
        wr_ready  = 1'b0;
        wr_go     = 1'b0;
        rd_go     = 1'b0;
        rd_elig   = 1'b0;
        burst_nxt = burst;
        if (!run) begin
            ph = OFF;
        end else if (state == OFF) begin
            ph = WR_PH;
        end
        state_nxt = ph;
        rd_elig   = (ph != OFF) && cfg_replay_en && (rec_count != '0) && (credit != '0);
        case (ph)
            WR_PH: begin
                wr_ready = 1'b1;
                wr_go    = wr_vld;
                if (wr_go) begin
                    if (!rd_elig) begin
                        burst_nxt = '0;
                    end else if (burst == BURST_W'(WR_WEIGHT - 1)) begin
                        state_nxt = RD_PH;
                        burst_nxt = '0;
                    end else begin
                        burst_nxt = burst + 1'b1;
                    end
                end else if (rd_elig) begin
                    state_nxt = RD_PH;
                    burst_nxt = '0;
                end
            end
            RD_PH: begin
                rd_go = rd_elig;
                if (rd_go) begin
                    if (!wr_vld) begin
                        burst_nxt = '0;
                    end else if (burst == BURST_W'(RD_WEIGHT - 1)) begin
                        state_nxt = WR_PH;
                        burst_nxt = '0;
                    end else begin
                        burst_nxt = burst + 1'b1;
                    end
                end else if (wr_vld) begin
                    state_nxt = WR_PH;
                    burst_nxt = '0;
                end
            end
            default: begin
                state_nxt = OFF;
                burst_nxt = '0;
            end
        endcase
    end

    // Region capture on enable edge, record/replay pointers and record count.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            cfg_en_q  <= 1'b0;
            base_q    <= '0;
            limit_q   <= '0;
            rec_ptr   <= '0;
            rep_ptr   <= '0;
            rec_count <= '0;
        end else begin
            cfg_en_q <= cfg_enable;
            if (en_rise) begin
                base_q    <= cfg_base;
                limit_q   <= cfg_limit;
                rec_ptr   <= cfg_base;
                rep_ptr   <= cfg_base;
                rec_count <= '0;
            end else begin
                if (wr_go) begin
                    rec_ptr <= (rec_ptr == limit_q) ? base_q : rec_ptr + 1'b1;
                    if (!rec_full) begin
                        rec_count <= rec_count + 1'b1;
                    end
                end
                if (rd_go) begin
                    rep_ptr <= rep_last ? base_q : rep_ptr + 1'b1;
                end
            end
        end
    end

    // Registered QDR command outputs; address/data hold between commands.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            user_app_wr_cmd0  <= 1'b0;
            user_app_wr_addr0 <= '0;
            user_app_wr_data0 <= '0;
            user_app_rd_cmd0  <= 1'b0;
            user_app_rd_addr0 <= '0;
        end else begin
            user_app_wr_cmd0 <= wr_go;
            user_app_rd_cmd0 <= rd_go;
            if (wr_go) begin
                user_app_wr_addr0 <= rec_ptr;
                user_app_wr_data0 <= wr_data;
            end
            if (rd_go) begin
                user_app_rd_addr0 <= rep_ptr;
            end
        end
    end

    // Reads in flight to the QDR; unmatched returns are discarded.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            outstanding <= '0;
        end else begin
            outstanding <= outstanding + CNT_W'(rd_go) - CNT_W'(ret_ok);
        end
    end

    dflow_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (RD_FIFO_DEPTH)
    ) u_ret_fifo (
        .clk       (clk),
        .rst_n     (aresetn),
        .push      (ret_ok),
        .push_data (user_app_rd_data0),
        .pop       (rd_ready),
        .pop_data  (rd_data),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

`ifdef DFLOW_QDR_SCHED_STATS_EN
    logic [31:0] wr_cnt_q;
    logic [31:0] rd_cnt_q;
    logic [31:0] drop_cnt_q;

    // Free-running statistics, wrapping at 2^32.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (wr_go) begin
                wr_cnt_q <= wr_cnt_q + 1'b1;
            end
            if (rd_go) begin
                rd_cnt_q <= rd_cnt_q + 1'b1;
            end
            if (user_app_rd_valid0 && (outstanding == '0)) begin
                drop_cnt_q <= drop_cnt_q + 1'b1;
            end
        end
    end

    assign stat_wr_cnt   = wr_cnt_q;
    assign stat_rd_cnt   = rd_cnt_q;
    assign stat_drop_cnt = drop_cnt_q;
`else
    assign stat_wr_cnt   = '0;
    assign stat_rd_cnt   = '0;
    assign stat_drop_cnt = '0;
`endif

endmodule

// File: tb/tb_dflow_qdr_sched.sv
// Directed bench for dflow_qdr_sched with a behavioural QDR responder.
module tb_dflow_qdr_sched;

`ifdef DFLOW_QDR_SCHED_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic         clk;
    logic         aresetn;
    logic         cfg_enable;
    logic         cfg_replay_en;
    logic [18:0]  cfg_base;
    logic [18:0]  cfg_limit;
    logic [19:0]  rec_count;
    logic [143:0] wr_data;
    logic         wr_vld;
    logic         wr_ready;
    logic [143:0] rd_data;
    logic         rd_vld;
    logic         rd_ready;
    logic         init_calib_complete;
    logic         user_app_wr_cmd0;
    logic [18:0]  user_app_wr_addr0;
    logic [143:0] user_app_wr_data0;
    logic         user_app_rd_cmd0;
    logic [18:0]  user_app_rd_addr0;
    logic         user_app_rd_valid0;
    logic [143:0] user_app_rd_data0;
    logic [31:0]  stat_wr_cnt;
    logic [31:0]  stat_rd_cnt;
    logic [31:0]  stat_drop_cnt;

    int errors = 0;
    int checks = 0;

    logic [143:0] qmem [0:255];
    logic [143:0] ret_q[$];
    logic [18:0]  rd_log[$];
    bit           cmd_log[$];
    bit           ret_en;
    int           both_cnt;

    dflow_qdr_sched #(
        .ADDR_W        (19),
        .DATA_W        (144),
        .RD_FIFO_DEPTH (16),
        .WR_WEIGHT     (4),
        .RD_WEIGHT     (4)
    ) dut (
        .clk                 (clk),
        .aresetn             (aresetn),
        .cfg_enable          (cfg_enable),
        .cfg_replay_en       (cfg_replay_en),
        .cfg_base            (cfg_base),
        .cfg_limit           (cfg_limit),
        .rec_count           (rec_count),
        .wr_data             (wr_data),
        .wr_vld              (wr_vld),
        .wr_ready            (wr_ready),
        .rd_data             (rd_data),
        .rd_vld              (rd_vld),
        .rd_ready            (rd_ready),
        .init_calib_complete (init_calib_complete),
        .user_app_wr_cmd0    (user_app_wr_cmd0),
        .user_app_wr_addr0   (user_app_wr_addr0),
        .user_app_wr_data0   (user_app_wr_data0),
        .user_app_rd_cmd0    (user_app_rd_cmd0),
        .user_app_rd_addr0   (user_app_rd_addr0),
        .user_app_rd_valid0  (user_app_rd_valid0),
        .user_app_rd_data0   (user_app_rd_data0),
        .stat_wr_cnt         (stat_wr_cnt),
        .stat_rd_cnt         (stat_rd_cnt),
        .stat_drop_cnt       (stat_drop_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1);
    end

    function automatic logic [143:0] d_of(input int i);
        logic [15:0] h;
        h = 16'(i * 291 + 23040);
        return {9{h}};
    endfunction

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // QDR responder: stores writes, queues read data, returns when enabled.
    initial begin
        user_app_rd_valid0 = 1'b0;
        user_app_rd_data0  = '0;
        both_cnt = 0;
        for (int i = 0; i < 256; i++) qmem[i] = '0;
        forever begin
            @(posedge clk);
            #1;
            user_app_rd_valid0 = 1'b0;
            if (ret_en && ret_q.size() > 0) begin
                user_app_rd_valid0 = 1'b1;
                user_app_rd_data0  = ret_q.pop_front();
            end
            if (user_app_wr_cmd0 && user_app_rd_cmd0) both_cnt++;
            if (user_app_wr_cmd0) begin
                qmem[user_app_wr_addr0[7:0]] = user_app_wr_data0;
                cmd_log.push_back(1'b1);
            end
            if (user_app_rd_cmd0) begin
                rd_log.push_back(user_app_rd_addr0);
                ret_q.push_back(qmem[user_app_rd_addr0[7:0]]);
                cmd_log.push_back(1'b0);
            end
        end
    end

    task automatic restart(input logic [18:0] base, input logic [18:0] limit);
        cfg_enable = 1'b0;
        tick();
        cfg_base   = base;
        cfg_limit  = limit;
        cfg_enable = 1'b1;
        tick();
        tick();
    endtask

    initial begin
        int bad;
        int k;
        logic [4:0] first5;
        logic [3:0] grp;

        ret_en              = 1'b1;
        aresetn             = 1'b0;
        cfg_enable          = 1'b0;
        cfg_replay_en       = 1'b0;
        cfg_base            = '0;
        cfg_limit           = '0;
        wr_data             = '0;
        wr_vld              = 1'b0;
        rd_ready            = 1'b0;
        init_calib_complete = 1'b0;

        // Reset values
        tick();
        tick();
        chk("rst_wr_cmd", user_app_wr_cmd0, 0);
        chk("rst_rd_cmd", user_app_rd_cmd0, 0);
        chk("rst_wr_addr", user_app_wr_addr0, 0);
        chk("rst_wr_data", user_app_wr_data0, 0);
        chk("rst_rd_addr", user_app_rd_addr0, 0);
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_rd_vld", rd_vld, 0);
        chk("rst_rec_count", rec_count, 0);
        chk("rst_stats", {stat_wr_cnt, stat_rd_cnt, stat_drop_cnt}, 0);

        // Calibration gating with region 10..13
        aresetn    = 1'b1;
        cfg_base   = 19'd10;
        cfg_limit  = 19'd13;
        cfg_enable = 1'b1;
        wr_vld     = 1'b1;
        wr_data    = d_of(0);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (wr_ready || user_app_wr_cmd0 || user_app_rd_cmd0) bad++;
        end
        chk("calib_gate_quiet", bad, 0);
        init_calib_complete = 1'b1;
        #1;
        chk("calib_wr_ready", wr_ready, 1);

        // Record wrap: 6 writes into a 4-entry region
        for (int i = 0; i < 6; i++) begin
            wr_data = d_of(i);
            tick();
            if (i == 5) wr_vld = 1'b0;
            chk("wrap_wr_cmd", user_app_wr_cmd0, 1);
            chk("wrap_wr_addr", user_app_wr_addr0, 10 + (i % 4));
            chk("wrap_wr_data", user_app_wr_data0, d_of(i));
        end
        tick();
        chk("wrap_cmd_idle", user_app_wr_cmd0, 0);
        chk("wrap_rec_count", rec_count, 4);
        chk("wrap_stat_wr", stat_wr_cnt, STATS ? 6 : 0);

        // Replay wrap on partial fill: 3 records at base 0
        restart(19'd0, 19'd100);
        wr_vld = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_data = d_of(10 + i);
            tick();
        end
        wr_vld = 1'b0;
        tick();
        chk("part_rec_count", rec_count, 3);
        rd_log.delete();
        rd_ready      = 1'b1;
        cfg_replay_en = 1'b1;
        k = 0;
        for (int c = 0; c < 200 && k < 6; c++) begin
            tick();
            if (rd_vld) begin
                chk("part_rd_data", rd_data, d_of(10 + (k % 3)));
                k++;
            end
        end
        chk("part_beats", k, 6);
        for (int i = 0; i < 6; i++) begin
            chk("part_rd_addr", (rd_log.size() > i) ? rd_log[i] : 19'h7ffff, i % 3);
        end
        cfg_replay_en = 1'b0;
        repeat (30) tick();

        // Credit limit: 40 records stored, no pops
        restart(19'd0, 19'd63);
        wr_vld = 1'b1;
        for (int i = 0; i < 40; i++) begin
            wr_data = d_of(100 + i);
            tick();
        end
        wr_vld = 1'b0;
        tick();
        chk("credit_rec_count", rec_count, 40);
        rd_ready = 1'b0;
        rd_log.delete();
        cfg_replay_en = 1'b1;
        repeat (60) tick();
        chk("credit_rd_cmds", rd_log.size(), 16);
        chk("credit_last_addr", (rd_log.size() > 15) ? rd_log[15] : 19'h7ffff, 15);
        chk("credit_rd_vld", rd_vld, 1);
        chk("credit_head", rd_data, d_of(100));
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        repeat (10) tick();
        chk("credit_after_pop", rd_log.size(), 17);
        cfg_replay_en = 1'b0;
        rd_ready = 1'b1;
        repeat (40) tick();
        chk("credit_drained", rd_vld, 0);

        // Weighted arbitration, both paths saturated
        restart(19'd0, 19'd1000);
        cmd_log.delete();
        both_cnt      = 0;
        wr_data       = d_of(7);
        wr_vld        = 1'b1;
        cfg_replay_en = 1'b1;
        repeat (50) tick();
        wr_vld        = 1'b0;
        cfg_replay_en = 1'b0;
        chk("wrr_cmd_count", cmd_log.size() >= 37, 1);
        chk("wrr_one_cmd", both_cnt, 0);
        if (cmd_log.size() >= 37) begin
            first5 = {cmd_log[0], cmd_log[1], cmd_log[2], cmd_log[3], cmd_log[4]};
            chk("wrr_first_writes", first5, 5'b11111);
            for (int g = 0; g < 8; g++) begin
                grp = {cmd_log[5 + 4*g], cmd_log[6 + 4*g], cmd_log[7 + 4*g], cmd_log[8 + 4*g]};
                chk("wrr_group", grp, (g % 2 == 0) ? 4'b0000 : 4'b1111);
            end
        end
        repeat (30) tick();

        // Reset with 5 reads outstanding, then late returns
        ret_en = 1'b0;
        rd_log.delete();
        cfg_replay_en = 1'b1;
        for (int c = 0; c < 50; c++) begin
            tick();
            if (rd_log.size() >= 5) break;
        end
        cfg_replay_en = 1'b0;
        tick();
        tick();
        chk("drop_outstanding", rd_log.size(), 5);
        aresetn = 1'b0;
        #1;
        chk("arst_wr_cmd", user_app_wr_cmd0, 0);
        chk("arst_rd_cmd", user_app_rd_cmd0, 0);
        chk("arst_addrs", {user_app_wr_addr0, user_app_rd_addr0}, 0);
        chk("arst_wr_data", user_app_wr_data0, 0);
        chk("arst_wr_ready", wr_ready, 0);
        chk("arst_rd_vld", rd_vld, 0);
        chk("arst_rec_count", rec_count, 0);
        chk("arst_stats", {stat_wr_cnt, stat_rd_cnt, stat_drop_cnt}, 0);
        tick();
        aresetn = 1'b1;
        tick();
        ret_en = 1'b1;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (rd_vld) bad++;
        end
        chk("drop_rd_vld_quiet", bad, 0);
        chk("drop_stat", stat_drop_cnt, STATS ? 5 : 0);
        chk("drop_stat_rd", stat_rd_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
